uart_tx_dma: RTL and testbench

//  Bus-master engine that copies a byte buffer from memory into the UART TX register.

---
 rtl/uart_tx_dma_pkg.sv | 30 +++
 rtl/uart_tx_dma.sv | 209 ++++++++++++++++++++
 tb/tb_uart_tx_dma.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_dma_pkg.sv
// Shared types and constants for the UART TX DMA engine: FSM states,
// register map offsets and the UART register layout it talks to.
package uart_tx_dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    ST_REQ,
    ST_WAIT,
    WR_REQ,
    WR_WAIT
  } state_e;

  localparam logic [11:0] REG_SRC  = 12'h000;
  localparam logic [11:0] REG_LEN  = 12'h004;
  localparam logic [11:0] REG_CTRL = 12'h008;
  localparam logic [11:0] REG_STAT = 12'h00C;

  localparam int unsigned CTRL_START_BIT  = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT = 1;
  localparam int unsigned STAT_BUSY_BIT   = 0;
  localparam int unsigned STAT_DONE_BIT   = 1;

  localparam logic [31:0] UART_TX_OFF     = 32'h4;
  localparam logic [31:0] UART_STATUS_OFF = 32'h8;

  localparam int unsigned STATUS_TX_FULL_BIT = 1;

endpackage

// File: rtl/uart_tx_dma.sv
// Bus-master engine that streams a byte buffer from memory into the UART TX
// register, polling UART STATUS before every byte so the CPU does not have to.
module uart_tx_dma
  import uart_tx_dma_pkg::*;
#(
  parameter int unsigned          AddrWidth = 32,
  parameter int unsigned          DataWidth = 32,
  parameter int unsigned          RegAddr   = 12,
  parameter int unsigned          LenWidth  = 16,
  parameter logic [AddrWidth-1:0] UartBase  = 32'h8000_1000
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 device_req_i,
  input  logic [AddrWidth-1:0] device_addr_i,
  input  logic                 device_we_i,
  input  logic [3:0]           device_be_i,
  input  logic [DataWidth-1:0] device_wdata_i,
  output logic                 device_rvalid_o,
  output logic [DataWidth-1:0] device_rdata_o,
  output logic                 host_req_o,
  input  logic                 host_gnt_i,
  output logic [AddrWidth-1:0] host_addr_o,
  output logic                 host_we_o,
  output logic [3:0]           host_be_o,
  output logic [DataWidth-1:0] host_wdata_o,
  input  logic                 host_rvalid_i,
  input  logic [DataWidth-1:0] host_rdata_i,
  output logic                 dma_irq_o
);

  function automatic logic [DataWidth-1:0] be_merge(input logic [DataWidth-1:0] old_v,
                                                    input logic [DataWidth-1:0] new_v,
                                                    input logic [3:0]           be);
    logic [DataWidth-1:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[i*8 +: 8] = new_v[i*8 +: 8];
    end
    return res;
  endfunction

  state_e state_q, state_d;

  logic [AddrWidth-1:0] src_q, src_d, ptr_q, ptr_d, ptr_inc;
  logic [LenWidth-1:0]  len_q, len_d, cnt_q, cnt_d;
  logic [DataWidth-1:0] word_q, word_d, rdata_q, rdata_d;
  logic                 irq_en_q, irq_en_d, done_q, done_d, rvalid_q, rvalid_d;

  logic [RegAddr-1:0] reg_off;
  logic               busy, wr_src, wr_len, wr_ctrl, wr_stat, start, done_set, done_clr;
  logic               last_byte;
  logic [7:0]         tx_byte;
  logic               unused_addr;

  assign reg_off     = device_addr_i[RegAddr-1:0];
  assign unused_addr = ^device_addr_i[AddrWidth-1:RegAddr];
  assign busy        = (state_q != IDLE);
  assign ptr_inc     = ptr_q + AddrWidth'(1);
  assign last_byte   = (cnt_q == LenWidth'(1));
  assign tx_byte     = word_q[{ptr_q[1:0], 3'b000} +: 8];

  always_comb begin
    wr_src   = device_req_i & device_we_i & (reg_off == RegAddr'(REG_SRC));
    wr_len   = device_req_i & device_we_i & (reg_off == RegAddr'(REG_LEN));
    wr_ctrl  = device_req_i & device_we_i & (reg_off == RegAddr'(REG_CTRL)) & device_be_i[0];
    wr_stat  = device_req_i & device_we_i & (reg_off == RegAddr'(REG_STAT)) & device_be_i[0];
    start    = wr_ctrl & device_wdata_i[CTRL_START_BIT] & ~busy;
    done_clr = wr_stat & device_wdata_i[STAT_DONE_BIT];
    done_set = (start & (len_q == '0)) |
               ((state_q == WR_WAIT) & host_rvalid_i & last_byte);
  end

  // Register file and device-port read path; DONE set beats a same-cycle w1c.
  always_comb begin
    src_d    = src_q;
    len_d    = len_q;
    irq_en_d = irq_en_q;
    done_d   = done_q;
    rvalid_d = device_req_i;
    rdata_d  = '0;
    if (wr_src && !busy) src_d = AddrWidth'(be_merge(DataWidth'(src_q), device_wdata_i, device_be_i));
    if (wr_len && !busy) len_d = LenWidth'(be_merge(DataWidth'(len_q), device_wdata_i, device_be_i));
    if (wr_ctrl) irq_en_d = device_wdata_i[CTRL_IRQ_EN_BIT];
    if (done_clr) done_d = 1'b0;
    if (done_set) done_d = 1'b1;
    if (device_req_i && !device_we_i) begin
      if (reg_off == RegAddr'(REG_SRC)) begin
        rdata_d = DataWidth'(src_q);
      end else if (reg_off == RegAddr'(REG_LEN)) begin
        rdata_d = DataWidth'(len_q);
      end else if (reg_off == RegAddr'(REG_CTRL)) begin
        rdata_d[CTRL_IRQ_EN_BIT] = irq_en_q;
      end else if (reg_off == RegAddr'(REG_STAT)) begin
        rdata_d[STAT_BUSY_BIT] = busy;
        rdata_d[STAT_DONE_BIT] = done_q;
      end
    end
  end

  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    word_d = word_q;
    case (state_q)
      IDLE: begin
        if (start && len_q != '0) begin
          ptr_d = src_q;
          cnt_d = len_q;
        end
      end
      RD_WAIT: if (host_rvalid_i) word_d = host_rdata_i;
      WR_WAIT: begin
        if (host_rvalid_i) begin
          ptr_d = ptr_inc;
          cnt_d = cnt_q - LenWidth'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_q    <= '0;
      len_q    <= '0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      word_q   <= '0;
    end else begin
      src_q    <= src_d;
      len_q    <= len_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      word_q   <= word_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // A word is re-read only when the pointer crosses into the next aligned word.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && len_q != '0) state_d = RD_REQ;
      RD_REQ:  if (host_gnt_i) state_d = RD_WAIT;
      RD_WAIT: if (host_rvalid_i) state_d = ST_REQ;
      ST_REQ:  if (host_gnt_i) state_d = ST_WAIT;
      ST_WAIT: begin
        if (host_rvalid_i) begin
          state_d = host_rdata_i[STATUS_TX_FULL_BIT] ? ST_REQ : WR_REQ;
        end
      end
      WR_REQ:  if (host_gnt_i) state_d = WR_WAIT;
      WR_WAIT: begin
        if (host_rvalid_i) begin
          if (last_byte)                state_d = IDLE;
          else if (ptr_inc[1:0] == '0) state_d = RD_REQ;
          else                          state_d = ST_REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    host_req_o   = 1'b0;
    host_addr_o  = '0;
    host_we_o    = 1'b0;
    host_be_o    = 4'h0;
    host_wdata_o = '0;
    case (state_q)
      RD_REQ: begin
        host_req_o  = 1'b1;
        host_addr_o = {ptr_q[AddrWidth-1:2], 2'b00};
        host_be_o   = 4'hF;
      end
      ST_REQ: begin
        host_req_o  = 1'b1;
        host_addr_o = UartBase + AddrWidth'(UART_STATUS_OFF);
        host_be_o   = 4'hF;
      end
      WR_REQ: begin
        host_req_o   = 1'b1;
        host_addr_o  = UartBase + AddrWidth'(UART_TX_OFF);
        host_we_o    = 1'b1;
        host_be_o    = 4'b0001;
        host_wdata_o = DataWidth'(tx_byte);
      end
      default: ;
    endcase
  end

  assign device_rvalid_o = rvalid_q;
  assign device_rdata_o  = rdata_q;
  assign dma_irq_o       = done_q & irq_en_q;

endmodule

// File: tb/tb_uart_tx_dma.sv
// Randomized bench for uart_tx_dma: a memory/UART slave logs every host
// transaction and compares it with a byte-level model of the copy.
module tb_uart_tx_dma;

  localparam logic [31:0] UART_BASE = 32'h8000_1000;
  localparam logic [31:0] A_SRC = 32'h0, A_LEN = 32'h4, A_CTRL = 32'h8, A_STAT = 32'hC;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [7:0]  data;
  } txn_t;

  logic        clk_i = 1'b0, rst_ni = 1'b0;
  logic        device_req_i = 1'b0, device_we_i = 1'b0;
  logic [31:0] device_addr_i = '0, device_wdata_i = '0;
  logic [3:0]  device_be_i = 4'hF;
  logic        device_rvalid_o;
  logic [31:0] device_rdata_o;
  logic        host_req_o, host_we_o, host_gnt_i, host_rvalid_i, dma_irq_o;
  logic [31:0] host_addr_o, host_wdata_o, host_rdata_i;
  logic [3:0]  host_be_o;

  uart_tx_dma dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .device_req_i(device_req_i), .device_addr_i(device_addr_i), .device_we_i(device_we_i),
    .device_be_i(device_be_i), .device_wdata_i(device_wdata_i),
    .device_rvalid_o(device_rvalid_o), .device_rdata_o(device_rdata_o),
    .host_req_o(host_req_o), .host_gnt_i(host_gnt_i), .host_addr_o(host_addr_o),
    .host_we_o(host_we_o), .host_be_o(host_be_o), .host_wdata_o(host_wdata_o),
    .host_rvalid_i(host_rvalid_i), .host_rdata_i(host_rdata_i), .dma_irq_o(dma_irq_o)
  );

  always #5 clk_i = ~clk_i;

  int tests_run = 0, tests_failed = 0;

  logic [31:0] mem [256];
  txn_t obs_q[$], exp_q[$];
  int   fulls_q[$];
  int   full_left = 0, max_stall = 0;
  bit   block_writes = 0, req_seen = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Memory + UART slave: one outstanding transaction, random grant stalls,
  // stray rvalid pulses while a request is still waiting for its grant.
  initial begin
    bit          pending;
    logic [31:0] resp;
    int          stall, stall_target;
    txn_t        t;
    pending = 0; resp = '0; stall = 0; stall_target = 0;
    host_gnt_i = 0; host_rvalid_i = 0; host_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      host_gnt_i = 0;
      host_rvalid_i = 0;
      if (!rst_ni) begin
        pending = 0;
        stall = 0;
      end else if (pending) begin
        host_rvalid_i = 1;
        host_rdata_i = resp;
        pending = 0;
      end else if (host_req_o) begin
        req_seen = 1;
        if (host_we_o && block_writes) begin
        end else if (stall < stall_target) begin
          stall++;
          host_rvalid_i = 1'($urandom_range(0, 1));
          host_rdata_i = $urandom;
        end else begin
          host_gnt_i = 1;
          stall = 0;
          stall_target = $urandom_range(0, max_stall);
          t.we = host_we_o;
          t.be = host_be_o;
          t.addr = host_addr_o;
          t.data = host_we_o ? host_wdata_o[7:0] : 8'h00;
          obs_q.push_back(t);
          if (host_we_o) begin
            resp = '0;
            if (fulls_q.size() > 0) void'(fulls_q.pop_front());
            full_left = (fulls_q.size() > 0) ? fulls_q[0] : 0;
          end else if (host_addr_o == UART_BASE + 32'h8) begin
            resp = $urandom & ~32'h2;
            if (full_left > 0) begin
              resp = resp | 32'h2;
              full_left--;
            end
          end else begin
            resp = mem[host_addr_o[9:2]];
          end
          pending = 1;
        end
      end
    end
  end

  task automatic regWrite(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk_i);
    device_req_i = 1; device_we_i = 1; device_addr_i = addr; device_wdata_i = data; device_be_i = 4'hF;
    @(negedge clk_i);
    device_req_i = 0; device_we_i = 0;
  endtask

  task automatic regRead(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk_i);
    device_req_i = 1; device_we_i = 0; device_addr_i = addr;
    @(negedge clk_i);
    checkOutput("rvalid", 64'(device_rvalid_o), 64'd1);
    data = device_rdata_o;
    device_req_i = 0;
  endtask

  task automatic waitIdle(input string tag);
    logic [31:0] d;
    int n;
    n = 0;
    do begin
      regRead(A_STAT, d);
      n++;
    end while (d[0] && n < 2000);
    checkOutput({tag, "_busy_timeout"}, 64'(d[0]), 64'd0);
  endtask

  // Reference: per byte, fetch the aligned word when starting or entering a
  // new word, poll STATUS (fulls+1 times), then send the selected byte.
  task automatic buildExpected(input logic [31:0] src, input int len, input int fulls[$]);
    logic [31:0] p;
    txn_t t;
    p = src;
    exp_q.delete();
    for (int i = 0; i < len; i++) begin
      if (i == 0 || p % 4 == 0) begin
        t = '{we: 1'b0, be: 4'hF, addr: p - (p % 4), data: 8'h00};
        exp_q.push_back(t);
      end
      for (int k = 0; k <= fulls[i]; k++) begin
        t = '{we: 1'b0, be: 4'hF, addr: UART_BASE + 32'h8, data: 8'h00};
        exp_q.push_back(t);
      end
      t = '{we: 1'b1, be: 4'h1, addr: UART_BASE + 32'h4,
            data: 8'((mem[(p / 4) % 256] >> (8 * (p % 4))) & 32'hFF)};
      exp_q.push_back(t);
      p = p + 1;
    end
  endtask

  task automatic compareTxns(input string tag);
    int n;
    checkOutput({tag, "_txn_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) checkOutput($sformatf("%s_txn%0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
  endtask

  task automatic applyStimulus(input string tag, input logic [31:0] src, input int len,
                               input int fulls[$], input bit poke_busy);
    logic [31:0] d;
    obs_q.delete();
    fulls_q = fulls;
    full_left = fulls[0];
    buildExpected(src, len, fulls);
    regWrite(A_SRC, src);
    regWrite(A_LEN, 32'(len));
    regWrite(A_CTRL, 32'h1);
    if (poke_busy) begin
      regWrite(A_SRC, 32'h200);
      regWrite(A_LEN, 32'h2);
      regWrite(A_CTRL, 32'h1);
    end
    waitIdle(tag);
    compareTxns(tag);
    regRead(A_STAT, d);
    checkOutput({tag, "_stat"}, 64'(d), 64'h2);
    if (poke_busy) begin
      regRead(A_SRC, d);
      checkOutput({tag, "_src_kept"}, 64'(d), 64'(src));
      regRead(A_LEN, d);
      checkOutput({tag, "_len_kept"}, 64'(d), 64'(len));
    end
    regWrite(A_STAT, 32'h2);
  endtask

  initial begin
    logic [31:0] d;
    int fl[$];
    bit found;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[8'h40] = 32'h4433_2211;
    mem[8'h41] = 32'h8877_6655;
    repeat (3) @(negedge clk_i);
    checkOutput("rst_host_req", 64'(host_req_o), 64'd0);
    checkOutput("rst_rvalid", 64'(device_rvalid_o), 64'd0);
    checkOutput("rst_irq", 64'(dma_irq_o), 64'd0);
    rst_ni = 1;
    foreach (fl[i]) fl.delete();
    regRead(A_SRC, d);  checkOutput("rst_src", 64'(d), 64'd0);
    regRead(A_LEN, d);  checkOutput("rst_len", 64'(d), 64'd0);
    regRead(A_STAT, d); checkOutput("rst_stat", 64'(d), 64'd0);
    regRead(32'h10, d); checkOutput("unmapped", 64'(d), 64'd0);

    fl = '{0, 0, 0, 0};
    applyStimulus("aligned4", 32'h100, 4, fl, 0);
    checkOutput("aligned4_first_byte", 64'(obs_q[2].data), 64'h11);
    checkOutput("aligned4_last_byte", 64'(obs_q[8].data), 64'h44);

    fl = '{0, 0, 0};
    applyStimulus("unaligned3", 32'h103, 3, fl, 0);

    fl = '{3};
    applyStimulus("full3", 32'h101, 1, fl, 0);

    req_seen = 0;
    regWrite(A_LEN, 32'h0);
    regWrite(A_CTRL, 32'h3);
    checkOutput("len0_irq", 64'(dma_irq_o), 64'd1);
    regRead(A_STAT, d);
    checkOutput("len0_stat", 64'(d), 64'h2);
    regRead(A_CTRL, d);
    checkOutput("ctrl_read", 64'(d), 64'h2);
    checkOutput("len0_no_req", 64'(req_seen), 64'd0);
    regWrite(A_STAT, 32'h2);
    checkOutput("w1c_irq", 64'(dma_irq_o), 64'd0);
    regWrite(A_CTRL, 32'h0);

    max_stall = 3;
    fl = '{1, 0, 2, 0, 1, 0};
    applyStimulus("busy_poke", 32'h110, 6, fl, 1);

    for (int it = 0; it < 6; it++) begin
      int len;
      len = $urandom_range(1, 10);
      max_stall = $urandom_range(0, 4);
      fl.delete();
      for (int i = 0; i < len; i++) fl.push_back($urandom_range(0, 2));
      applyStimulus($sformatf("rand%0d", it), 32'h100 + 32'($urandom_range(0, 255)), len, fl, 0);
    end

    max_stall = 0;
    block_writes = 1;
    fl = '{0, 0, 0, 0, 0, 0, 0, 0};
    fulls_q = fl;
    full_left = 0;
    regWrite(A_SRC, 32'h120);
    regWrite(A_LEN, 32'h8);
    regWrite(A_CTRL, 32'h3);
    found = 0;
    for (int n = 0; n < 400 && !found; n++) begin
      @(negedge clk_i);
      found = host_req_o && host_we_o;
    end
    checkOutput("reach_wr_req", 64'(found), 64'd1);
    repeat (5) @(negedge clk_i);
    checkOutput("wr_req_held", 64'(host_req_o), 64'd1);
    rst_ni = 0;
    @(posedge clk_i);
    #1;
    checkOutput("abort_req", 64'(host_req_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1;
    block_writes = 0;
    req_seen = 0;
    regRead(A_SRC, d);  checkOutput("abort_src", 64'(d), 64'd0);
    regRead(A_LEN, d);  checkOutput("abort_len", 64'(d), 64'd0);
    regRead(A_CTRL, d); checkOutput("abort_ctrl", 64'(d), 64'd0);
    regRead(A_STAT, d); checkOutput("abort_stat", 64'(d), 64'd0);
    repeat (20) @(negedge clk_i);
    checkOutput("abort_no_resume", 64'(req_seen), 64'd0);
    checkOutput("abort_irq", 64'(dma_irq_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
